// File: rtl/oh_lutram_dp_if.sv
// oh_lutram_dp_if -- port bundle for the dual-port LUT RAM.
//   wr_en/wr_addr/wr_din/wr_mask : port A write strobe, address, data, per-bit enable
//   rd_addr                      : port B read-only address
//   spo/dpo                      : read data at wr_addr / rd_addr
//   busy                         : clear sequencer active, port A writes dropped
// master drives addresses and write data; slave (the RAM) returns read data and busy.
interface oh_lutram_dp_if #(
   parameter int DW = 8,
   parameter int AW = 5
);
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_din;
   logic [DW-1:0] wr_mask;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] spo;
   logic [DW-1:0] dpo;
   logic          busy;

   modport master (
      output wr_en, wr_addr, wr_din, wr_mask, rd_addr,
      input  spo, dpo, busy
   );

   modport slave (
      input  wr_en, wr_addr, wr_din, wr_mask, rd_addr,
      output spo, dpo, busy
   );
endinterface

// File: rtl/oh_lutram_dp.sv
// oh_lutram_dp -- parametrised dual-port LUT RAM with per-bit write mask,
// optional registered (read-first) outputs and an optional post-reset clear.
//   clk   : single clock for writes, output registers and clear sequencer
//   reset : synchronous, active-high
//   bus   : oh_lutram_dp_if.slave (port A write/read, port B read, busy)
// Parameters: DW data width, AW address width (2^AW entries),
//   REG_OUT 0 = combinational reads, 1 = one-cycle registered reads,
//   CLEAR_EN 1 = zero every entry after reset, busy high meanwhile.
module oh_lutram_dp #(
   parameter int DW       = 8,
   parameter int AW       = 5,
   parameter int REG_OUT  = 0,
   parameter int CLEAR_EN = 1
) (
   input  logic          clk,
   input  logic          reset,
   oh_lutram_dp_if.slave bus
);

   localparam int DEPTH = 2 ** AW;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   state_t        state_q, state_d;
   // One extra bit so the carry out of the last entry marks completion.
   logic [AW:0]   clr_addr_q, clr_addr_d;
   logic          clr_we;
   logic          busy;
   logic          wr_ok;
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rd_spo;
   logic [DW-1:0] rd_dpo;

   function automatic logic [DW-1:0] mask_merge(input logic [DW-1:0] old_v,
                                                input logic [DW-1:0] new_v,
                                                input logic [DW-1:0] mask);
      return (old_v & ~mask) | (new_v & mask);
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_CLEAR;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      clr_we     = 1'b0;
      if ((CLEAR_EN != 0) && (state_q == S_CLEAR)) begin
         clr_we     = 1'b1;
         clr_addr_d = clr_addr_q + (AW+1)'(1);
         if (clr_addr_d[AW])
            state_d = S_IDLE;
      end
   end

   // busy covers the reset cycles themselves, not only the clear sweep.
   assign busy  = (CLEAR_EN != 0) && (reset || (state_q == S_CLEAR));
   assign wr_ok = bus.wr_en && !busy && !reset;

   // Array: clear sweep has priority; port A writes are dropped while busy.
   always_ff @(posedge clk) begin
      if (clr_we && !reset)
         mem[clr_addr_q[AW-1:0]] <= '0;
      else if (wr_ok)
         mem[bus.wr_addr] <= mask_merge(mem[bus.wr_addr], bus.wr_din, bus.wr_mask);
   end

   assign rd_spo   = mem[bus.wr_addr];
   assign rd_dpo   = mem[bus.rd_addr];
   assign bus.busy = busy;

   generate
      if (REG_OUT != 0) begin : g_reg
         // Output stage p1: samples pre-write content, giving read-first behaviour.
         logic [DW-1:0] spo_p1, dpo_p1;
         always_ff @(posedge clk) begin
            if (reset) begin
               spo_p1 <= '0;
               dpo_p1 <= '0;
            end else begin
               spo_p1 <= rd_spo;
               dpo_p1 <= rd_dpo;
            end
         end
         assign bus.spo = spo_p1;
         assign bus.dpo = dpo_p1;
      end else begin : g_async
         assign bus.spo = rd_spo;
         assign bus.dpo = rd_dpo;
      end
   endgenerate

endmodule
